mult_core: RTL
==============

# mult_core

Sequential multiplier that sits directly downstream of the DPRAM access controller. The controller loads operands A and B read from the dual-port RAM and pulses the enable. The core computes the full-width product with a radix-2 shift-add datapath and raises `done_o`. The controller then stores Y back to RAM and keeps `done_o` asserted until it clears its enable.

## Interface
- `WIDTH`, default 32: operand width in bits; product is 2*WIDTH.
- `SIGNED`, default 0: 0 = unsigned operands; 1 = two's-complement operands and product.

Ports:
- `clk_i` input 1: single clock, rising edge.
- `rst_i_n` input 1: asynchronous, active-low reset.
- `en_i` input 1: start request from controller, level-sensitive.
- `a_i` input WIDTH: multiplicand, sampled only on the start edge.
- `b_i` input WIDTH: multiplier, sampled only on the start edge.
- `busy_o` output 1: computation in progress.
- `done_o` output 1: result valid; held until `en_i` is low.
- `y_o` output 2*WIDTH: product, registered.
- `ovf_o` output 1: product does not fit in WIDTH bits (see Operation).

## Operation
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `y_o`=0, `ovf_o`=0, counter=0.
- IDLE
  - `en_i`=1 sampled: latch the operands (magnitudes when SIGNED=1), latch the result sign = sign(a) XOR sign(b), clear the accumulator, set counter=0, go to BUSY.
- BUSY, one iteration per cycle:
  - If the multiplier LSB is 1, the upper accumulator half += multiplicand, with the carry kept in an extra bit.
  - Then shift {carry, accumulator, multiplier} right by 1.
  - Counter increments.
  - After iteration WIDTH-1, go to FINISH.
- FINISH:
  - `y_o` = accumulator, two's-complement negated if SIGNED=1 and the sign bit is set.
  - `ovf_o`:
    - SIGNED=0: OR of `y_o`[2W-1:W].
    - SIGNED=1: `y_o`[2W-1:W-1] is not all-zeros or all-ones.
  - Go to DONE.
- DONE: `done_o`=1; stay while `en_i`=1; when `en_i`=0 is sampled, go to IDLE.
- `busy_o`=1 exactly in BUSY and FINISH.
- `y_o` and `ovf_o` hold their value until the next FINISH; they are not cleared on return to IDLE.
- Changes on `en_i`, `a_i` or `b_i` during BUSY/FINISH are ignored; there is no abort path except reset.
- `en_i` held high through DONE never causes a second computation. A low level must be sampled first, mirroring the controller's wait-for-clear state.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.
- Edge cases:
  - SIGNED=1 with operand -2^(W-1): magnitude 2^(W-1) is representable unsigned; no special case.
  - Zero operands run the full WIDTH iterations; there is no early exit.

## Timing
- Edge 0 samples `en_i`=1 in IDLE; `busy_o` goes high after edge 0.
- Edges 1..WIDTH are the BUSY iterations.
- Edge WIDTH+1 is FINISH → DONE; `done_o` and `y_o` are valid after edge WIDTH+1.
- Fixed latency: WIDTH+1 cycles from the sampling edge, independent of operand values and sign.
- `done_o` falls one edge after `en_i`=0 is sampled in DONE.
- Earliest restart: the edge after the return to IDLE.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `mult_core_pkg`:
  - enum `mult_state_e` {MULT_IDLE, MULT_BUSY, MULT_FINISH, MULT_DONE};
  - localparam default width 32.
  - The package is imported by `mult_core` and by the DPRAM controller, which reuses the handshake naming.
- Single module; no sub-module required.
- Counter width: $clog2(WIDTH).

## Test plan
- Unsigned 3 × 5, `en_i` held high: `busy_o` high cycles 1..33; `done_o` after edge 33; `y_o`=0x0000_0000_0000_000F; `ovf_o`=0; `done_o` drops one edge after `en_i` is released.
- 0xFFFF_FFFF × 0xFFFF_FFFF unsigned → `y_o`=0xFFFF_FFFE_0000_0001, `ovf_o`=1. Separately, 0 × 0x1234_5678 → 0 after the same 33-cycle latency.
- SIGNED=1:
  - -3 × 7 → `y_o`=0xFFFF_FFFF_FFFF_FFEB, `ovf_o`=0.
  - 0x8000_0000 × 0x8000_0000 → `y_o`=0x4000_0000_0000_0000, `ovf_o`=1.
- During BUSY, change `a_i`/`b_i` to 9/9 and toggle `en_i` → result stays 15; no restart. Holding `en_i` high for 10 cycles after `done_o` gives no second `busy_o` pulse.
- Assert `rst_i_n`=0 at cycle 10 of a computation → all outputs 0 immediately. After release, a new 2 × 2 request yields 4 with the full latency.
- Back-to-back requests: release `en_i` for one cycle after DONE, then re-assert with 6 × 7 → `y_o`=42; the previous `y_o` is held until the second FINISH.

Source files
------------

// File: rtl/mult_core_pkg.sv
// Shared types for the sequential multiplier and the DPRAM controller that drives it.
package mult_core_pkg;

  localparam int unsigned MULT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_BUSY,
    MULT_FINISH,
    MULT_DONE
  } mult_state_e;

endpackage

// File: rtl/mult_core.sv
// Radix-2 shift-add multiplier: WIDTH iterations, registered product, done held until en_i drops.
module mult_core
  import mult_core_pkg::*;
#(
  parameter int unsigned WIDTH  = MULT_WIDTH_DEF,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i_n,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   y_o,
  output logic                 ovf_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               sign_q, sign_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     y_top;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    sum      = '0;
    prod     = '0;
    y_top    = '0;

    unique case (state_q)
      MULT_IDLE: begin
        if (en_i) begin
          // Operate on magnitudes; -2^(W-1) negates to itself, which is the correct unsigned magnitude.
          mcand_d  = (SIGNED && a_i[WIDTH-1]) ? -a_i : a_i;
          mplier_d = (SIGNED && b_i[WIDTH-1]) ? -b_i : b_i;
          sign_d   = SIGNED && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MULT_BUSY;
        end
      end
      MULT_BUSY: begin
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = MULT_FINISH;
        end
      end
      MULT_FINISH: begin
        prod  = {acc_q, mplier_q};
        y_d   = (SIGNED && sign_q) ? -prod : prod;
        y_top = y_d[2*WIDTH-1:WIDTH-1];
        if (SIGNED) begin
          ovf_d = !((y_top == '0) || (y_top == '1));
        end else begin
          ovf_d = |y_d[2*WIDTH-1:WIDTH];
        end
        state_d = MULT_DONE;
      end
      MULT_DONE: begin
        if (!en_i) begin
          state_d = MULT_IDLE;
        end
      end
      default: state_d = MULT_IDLE;
    endcase

    busy_d = (state_d == MULT_BUSY) || (state_d == MULT_FINISH);
    done_d = (state_d == MULT_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_q  <= MULT_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_o    = y_q;
  assign ovf_o  = ovf_q;

endmodule
